mant_addsub_pipe: RTL and testbench
===================================

// Module: mant_addsub_pipe
// PURPOSE
//  Two-stage pipelined sign-magnitude mantissa add/subtract for the FP adder datapath.
//  Parametrised successor of the single-cycle block adder:
//   - internal magnitude compare, so no external Comp input
//   - valid/ready handshake with full backpressure
//   - sideband tag passthrough
//  Sits between exponent-align/shift and normalise/round.
// PARAMETERS
//  W     28  mantissa width incl. hidden, guard, round and sticky bits
//  TAGW  4   sideband tag width, carried unchanged alongside the data
// PORTS
//  clk        in   1     sole clock; all state updates on rising edge
//  rst        in   1     reset, synchronous, active-high
//  in_valid   in   1     input operands valid
//  in_ready   out  1     block can accept an input this cycle
//  sa, sb     in   1     operand signs
//  a, b       in   W     aligned operand magnitudes
//  a_s        in   1     operation: 0 add, 1 subtract
//  in_tag     in   TAGW  sideband tag
//  out_valid  out  1     result valid
//  out_ready  in   1     downstream accepts result
//  s          out  W     result magnitude
//  so         out  1     result sign
//  co         out  1     carry out; only set by an effective add
//  out_tag    out  TAGW  tag of the result
//  lzc        out  $clog2(W+1)  leading-zero count of s; present only with MANT_ADDSUB_LZC_EN
// BEHAVIOUR
//  Effective subtract: esub = sa ^ sb ^ a_s. Effective sign of b: sbe = sb ^ a_s.
//  Stage 1 (registered on an input accept):
//   - ge = (a >= b), unsigned compare
//   - big = ge ? a : b, small = ge ? b : a
//   - esub, tag, sign_big = ge ? sa : sbe
//  Stage 2 (registered output):
//   - esub=0: {co,s} = big + small (W+1 bits); so = sa
//   - esub=1: s = big - small, never negative; co = 0
//   - esub=1, exact-zero result: so = 0
//   - esub=1, otherwise: so = sign_big
//   - esub=0, zero result (e.g. -0 + -0): so = sa
//  Handshake, two valid bits v1/v2:
//   - adv = out_ready | ~v2
//   - in_ready = ~v1 | adv (combinational; no path from in_valid)
//   - input accept = in_valid & in_ready
//   - v2 loads v1 when adv; v1 loads the input accept when in_ready
//   - out_valid = v2; registered outputs hold stable while out_valid & ~out_ready
//  Latency: 2 cycles from accept to out_valid with no stalls.
//   Throughput: 1 result per cycle. Results keep input order.
//  Stall: out_ready=0 with both stages full -> in_ready=0; nothing is dropped or duplicated.
//  Simultaneous events:
//   - accept and drain in the same cycle are legal; full rate is kept
//   - out_ready rising while full: s2<-s1 and s1<-new input in the same cycle
//  Reset: rst=1 at any time, including mid-operation:
//   - next edge clears v1, v2, s, so, co, out_tag and lzc to 0
//   - in-flight operations are discarded; in_ready=1 from the cycle after reset
//  Widths: no truncation of the carry. a = b with esub=1 gives s=0, co=0, so=0.
// CONFIGURATION
//  MANT_ADDSUB_LZC_EN defined:
//   - lzc is registered in stage 2, aligned with s
//   - lzc = leading zeros of s; s=0 gives lzc=W
//  MANT_ADDSUB_LZC_EN not defined: lzc port and its logic are absent.
// STRUCTURE
//  Package fp_adder_pkg:
//   - OP_ADD=1'b0, OP_SUB=1'b1
//   - MANT_W=28 default
//   - typedef for the stage-1 record: big, small, esub, sign_big, tag
//  Sub-module lead_zero_count #(W):
//   - combinational priority count
//   - instantiated only under MANT_ADDSUB_LZC_EN
// TESTING (W=28)
//  1. a=0x10, b=0x3, sa=sb=0, a_s=0 -> 2 cycles later s=0x13, so=0, co=0
//     With LZC_EN: lzc=23.
//  2. a=0x3, b=0x10, sa=sb=0, a_s=1 -> s=0xD, so=1, co=0
//  3. a=b=0xFFFFFFF, add -> s=0xFFFFFFE, co=1
//     Same a=b with a_s=1, sa=0 -> s=0, so=0, co=0; with LZC_EN lzc=28.
//  4. out_ready=0, present 3 back-to-back inputs:
//     - first 2 accepted, then in_ready=0
//     - raise out_ready: 3 results appear in order with matching tags, none lost
//  5. Random stream, random in_valid/out_ready: results match a reference model in order.
//  6. Assert rst with both stages full:
//     - next cycle out_valid=0, s=0, in_ready=1
//     - no stale result appears later

Source files
------------

// File: rtl/fp_adder_pkg.sv
// Shared constants and types for the FP adder mantissa datapath.
package fp_adder_pkg;

    // Operation encoding on the a_s input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default mantissa width: hidden + fraction + guard, round and sticky bits.
    localparam int MANT_W = 28;
    localparam int TAG_W  = 4;

    // Stage-1 record at the default widths. The adder block builds the same
    // layout from its own parameters, so non-default widths stay consistent.
    typedef struct packed {
        logic [MANT_W-1:0] mag_big;
        logic [MANT_W-1:0] mag_small;
        logic              esub;
        logic              sign_big;
        logic [TAG_W-1:0]  tag;
    } st1_t;

endpackage

// File: rtl/lead_zero_count.sv
// Combinational leading-zero count. An all-zero input reports W.
module lead_zero_count #(
    parameter int W = 28
) (
    input  logic [W-1:0]             val_i,
    output logic [$clog2(W+1)-1:0]   cnt_o
);

    localparam int CW = $clog2(W+1);

    // Scan from LSB to MSB so the highest set bit determines the count.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (val_i[i]) begin
                cnt_o = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/mant_addsub_pipe.sv
// Two-stage sign-magnitude mantissa add/subtract with valid/ready backpressure.
// Stage 1 orders the operands by magnitude; stage 2 adds or subtracts them.
// Optional feature macro: MANT_ADDSUB_LZC_EN adds a registered leading-zero
// count output (lzc) aligned with s.
module mant_addsub_pipe
    import fp_adder_pkg::*;
#(
    parameter int W    = MANT_W,
    parameter int TAGW = TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sa,
    input  logic                     sb,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    input  logic                     a_s,
    input  logic [TAGW-1:0]          in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             s,
    output logic                     so,
    output logic                     co,
`ifdef MANT_ADDSUB_LZC_EN
    output logic [$clog2(W+1)-1:0]   lzc,
`endif
    output logic [TAGW-1:0]          out_tag
);

    typedef struct packed {
        logic [W-1:0]    mag_big;
        logic [W-1:0]    mag_small;
        logic            esub;
        logic            sign_big;
        logic [TAGW-1:0] tag;
    } st_rec_t;

    logic            vld_p1_q, vld_p2_q;
    logic            adv, acc;
    st_rec_t         st_p1_d, st_p1_q;
    logic [W-1:0]    s_p2_d, s_p2_q;
    logic            so_p2_d, so_p2_q;
    logic            co_p2_d, co_p2_q;
    logic [TAGW-1:0] tag_p2_q;
    logic [W:0]      sum_w;
    logic [W-1:0]    diff_w;

    // Stage 2 may advance when it is empty or being drained; stage 1 may take
    // a new operand when it is empty or moving on. No path from in_valid.
    assign adv      = out_ready | ~vld_p2_q;
    assign in_ready = ~vld_p1_q | adv;
    assign acc      = in_valid & in_ready;

    // Effective operation and magnitude ordering of the incoming operands.
    always_comb begin
        logic sbe;
        logic ge;
        st_p1_d           = '0;
        sbe               = sb ^ (a_s == OP_SUB);
        ge                = (a >= b);
        st_p1_d.mag_big   = ge ? a : b;
        st_p1_d.mag_small = ge ? b : a;
        st_p1_d.esub      = sa ^ sbe;
        st_p1_d.sign_big  = ge ? sa : sbe;
        st_p1_d.tag       = in_tag;
    end

    // ---- stage 1 boundary ----
    // Stage-1 valid: refilled (or emptied) whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (in_ready) begin
            vld_p1_q <= acc;
        end
    end

    // Stage-1 operand record, loaded only on an accepted input.
    always_ff @(posedge clk) begin
        if (acc) begin
            st_p1_q <= st_p1_d;
        end
    end

    // Magnitude add or subtract; big >= small so the difference is never negative.
    always_comb begin
        sum_w   = {1'b0, st_p1_q.mag_big} + {1'b0, st_p1_q.mag_small};
        diff_w  = st_p1_q.mag_big - st_p1_q.mag_small;
        s_p2_d  = sum_w[W-1:0];
        co_p2_d = sum_w[W];
        so_p2_d = st_p1_q.sign_big;
        if (st_p1_q.esub) begin
            s_p2_d  = diff_w;
            co_p2_d = 1'b0;
            // An exact cancellation is a positive zero.
            so_p2_d = (diff_w == '0) ? 1'b0 : st_p1_q.sign_big;
        end
    end

`ifdef MANT_ADDSUB_LZC_EN
    logic [$clog2(W+1)-1:0] lzc_p2_d, lzc_p2_q;

    lead_zero_count #(
        .W (W)
    ) u_lzc (
        .val_i (s_p2_d),
        .cnt_o (lzc_p2_d)
    );

    // Leading-zero count registered alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            lzc_p2_q <= '0;
        end else if (adv && vld_p1_q) begin
            lzc_p2_q <= lzc_p2_d;
        end
    end

    assign lzc = lzc_p2_q;
`endif

    // ---- stage 2 boundary ----
    // Output register: holds while stalled, only loads real stage-1 data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            s_p2_q   <= '0;
            so_p2_q  <= 1'b0;
            co_p2_q  <= 1'b0;
            tag_p2_q <= '0;
        end else if (adv) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                s_p2_q   <= s_p2_d;
                so_p2_q  <= so_p2_d;
                co_p2_q  <= co_p2_d;
                tag_p2_q <= st_p1_q.tag;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign s         = s_p2_q;
    assign so        = so_p2_q;
    assign co        = co_p2_q;
    assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_mant_addsub_pipe.sv
// Directed bench for mant_addsub_pipe (W=28, TAGW=4) with a short random
// stream checked against an arithmetic model.
module tb_mant_addsub_pipe;

    localparam int W    = 28;
    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            sa, sb, a_s;
    logic [W-1:0]    a, b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    s;
    logic            so, co;
    logic [TAGW-1:0] out_tag;
`ifdef MANT_ADDSUB_LZC_EN
    logic [$clog2(W+1)-1:0] lzc;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] expq[$];

    always #5 clk = ~clk;

    mant_addsub_pipe #(.W(W), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sa        (sa),
        .sb        (sb),
        .a         (a),
        .b         (b),
        .a_s       (a_s),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .so        (so),
        .co        (co),
`ifdef MANT_ADDSUB_LZC_EN
        .lzc       (lzc),
`endif
        .out_tag   (out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isa, input logic isb, input logic ias,
                         input logic [TAGW-1:0] it);
        a = ia; b = ib; sa = isa; sb = isb; a_s = ias; in_tag = it;
        in_valid = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] es,
                           input logic eso, input logic eco, input logic [TAGW-1:0] et);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".s"},     64'(s),         64'(es));
        chk({tag, ".so"},    64'(so),        64'(eso));
        chk({tag, ".co"},    64'(co),        64'(eco));
        chk({tag, ".tag"},   64'(out_tag),   64'(et));
    endtask

    // Signed-integer reference: evaluate the operation and split into sign/magnitude.
    function automatic logic [63:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic msa, input logic msb, input logic mas,
                                          input logic [TAGW-1:0] mt);
        longint va, vb, r;
        logic [63:0] mag;
        logic rs;
        va = longint'({36'b0, ma});
        vb = longint'({36'b0, mb});
        if (msa) va = -va;
        if (msb ^ mas) vb = -vb;
        r  = va + vb;
        rs = (r < 0);
        mag = rs ? 64'(-r) : 64'(r);
        if (r == 0) rs = (msa ^ msb ^ mas) ? 1'b0 : msa;
        return {30'b0, mag[W], rs, mt, mag[W-1:0]};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sa = 1'b0; sb = 1'b0; a_s = 1'b0; in_tag = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst.valid",    64'(out_valid), 64'(1'b0));
        chk("rst.s",        64'(s),         64'(0));
        chk("rst.so_co",    64'({so, co}),  64'(0));
        chk("rst.tag",      64'(out_tag),   64'(0));
        chk("rst.in_ready", 64'(in_ready),  64'(1'b1));

        // 0x10 + 0x3, two-cycle latency
        drive(28'h10, 28'h3, 1'b0, 1'b0, 1'b0, 4'h1);
        tick(); in_valid = 1'b0;
        chk("t1.lat1", 64'(out_valid), 64'(1'b0));
        tick();
        chk_out("t1", 28'h13, 1'b0, 1'b0, 4'h1);
`ifdef MANT_ADDSUB_LZC_EN
        chk("t1.lzc", 64'(lzc), 64'(23));
`endif
        tick();
        chk("t1.drained", 64'(out_valid), 64'(1'b0));

        // 0x3 - 0x10 -> negative result
        drive(28'h3, 28'h10, 1'b0, 1'b0, 1'b1, 4'h2);
        tick(); in_valid = 1'b0;
        tick();
        chk_out("t2", 28'hD, 1'b1, 1'b0, 4'h2);

        // max + max carries out; max - max is +0; back to back
        drive(28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 1'b0, 1'b0, 4'h3);
        tick();
        drive(28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 1'b0, 1'b1, 4'h4);
        tick(); in_valid = 1'b0;
        chk_out("t3add", 28'hFFFFFFE, 1'b0, 1'b1, 4'h3);
        tick();
        chk_out("t3sub", 28'h0, 1'b0, 1'b0, 4'h4);
`ifdef MANT_ADDSUB_LZC_EN
        chk("t3.lzc", 64'(lzc), 64'(28));
`endif

        // -0 + -0 keeps sign; -5 + 5 is +0; -2 + 7 = +5
        drive(28'h0, 28'h0, 1'b1, 1'b1, 1'b0, 4'h5);
        tick();
        drive(28'h5, 28'h5, 1'b1, 1'b0, 1'b0, 4'h6);
        tick();
        drive(28'h2, 28'h7, 1'b1, 1'b0, 1'b0, 4'h7);
        chk_out("negzero", 28'h0, 1'b1, 1'b0, 4'h5);
        tick(); in_valid = 1'b0;
        chk_out("cancel", 28'h0, 1'b0, 1'b0, 4'h6);
        tick();
        chk_out("mixsign", 28'h5, 1'b0, 1'b0, 4'h7);
        tick();

        // Backpressure: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        drive(28'h1, 28'h2, 1'b0, 1'b0, 1'b0, 4'h5);
        #1 chk("bp.rdy0", 64'(in_ready), 64'(1'b1));
        tick();
        drive(28'h100, 28'h1, 1'b0, 1'b0, 1'b1, 4'h6);
        chk("bp.rdy1", 64'(in_ready), 64'(1'b1));
        tick();
        drive(28'h8000000, 28'h8000000, 1'b1, 1'b1, 1'b0, 4'h7);
        #1 chk("bp.full", 64'(in_ready), 64'(1'b0));
        chk_out("bp.r1", 28'h3, 1'b0, 1'b0, 4'h5);
        tick();
        chk("bp.still", 64'(in_ready), 64'(1'b0));
        chk_out("bp.hold", 28'h3, 1'b0, 1'b0, 4'h5);
        out_ready = 1'b1;
        #1 chk("bp.release", 64'(in_ready), 64'(1'b1));
        tick(); in_valid = 1'b0;
        chk_out("bp.r2", 28'hFF, 1'b0, 1'b0, 4'h6);
        tick();
        chk_out("bp.r3", 28'h0, 1'b1, 1'b1, 4'h7);
        tick();
        chk("bp.empty", 64'(out_valid), 64'(1'b0));

        // Random stream against the model, random valid/ready
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = a >> $urandom_range(0, 27);
                b = b >> $urandom_range(0, 27);
            end
            sa = 1'($urandom); sb = 1'($urandom); a_s = 1'($urandom);
            in_tag = TAGW'($urandom);
            #1;
            if (in_valid && in_ready) expq.push_back(model(a, b, sa, sb, a_s, in_tag));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("rnd.extra", 64'(out_valid), 64'(1'b0));
                else chk("rnd.res", {30'b0, co, so, out_tag, s}, expq.pop_front());
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                if (expq.size() == 0) chk("drain.extra", 64'(out_valid), 64'(1'b0));
                else chk("drain.res", {30'b0, co, so, out_tag, s}, expq.pop_front());
            end
            tick();
        end
        chk("drain.left", 64'(expq.size()), 64'(0));
        chk("drain.idle", 64'(out_valid), 64'(1'b0));

        // Reset with both stages full
        out_ready = 1'b0;
        drive(28'h7, 28'h1, 1'b0, 1'b0, 1'b0, 4'h9);
        tick();
        drive(28'h2, 28'h3, 1'b0, 1'b0, 1'b0, 4'hA);
        tick(); in_valid = 1'b0;
        #1 chk("rst2.full", 64'({out_valid, in_ready}), 64'(2'b10));
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst2.valid",    64'(out_valid),          64'(1'b0));
        chk("rst2.s",        64'(s),                  64'(0));
        chk("rst2.misc",     64'({so, co, out_tag}),  64'(0));
        chk("rst2.in_ready", 64'(in_ready),           64'(1'b1));
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst2.stale", 64'(out_valid), 64'(1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
